wb_master_arb: RTL and testbench

//  Round-robin arbiter sharing the single 64-bit Wishbone master port of the DMA core between NREQ requesters:
//  the descriptor/control sequencer and the per-channel data movers.

---
 rtl/wb_master_arb_if.sv | 49 ++++
 rtl/wb_master_arb.sv | 186 ++++++++++++++++++
 tb/tb_wb_master_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_arb_if.sv
// Bundle of the requester-side and shared-port Wishbone signals around wb_master_arb.
// The master modport is the arbiter's view; slave is the environment's view.
interface wb_master_arb_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      m_cyc_i;
    logic [NREQ-1:0]      m_stb_i;
    logic [NREQ-1:0]      m_we_i;
    logic [NREQ-1:0]      m_cab_i;
    logic [4*NREQ-1:0]    m_sel_i;
    logic [32*NREQ-1:0]   m_adr_i;
    logic [32*NREQ-1:0]   m_dat_i;
    logic [32*NREQ-1:0]   m_dat64_i;
    logic [31:0]          m_dat_o;
    logic [31:0]          m_dat64_o;
    logic [NREQ-1:0]      m_ack_o;
    logic [NREQ-1:0]      m_err_o;
    logic [NREQ-1:0]      m_rty_o;

    logic                 wbs_cyc_o;
    logic                 wbs_stb_o;
    logic                 wbs_we_o;
    logic                 wbs_cab_o;
    logic [3:0]           wbs_sel_o;
    logic [31:0]          wbs_adr_o;
    logic [31:0]          wbs_dat_o;
    logic [31:0]          wbs_dat64_o;
    logic [31:0]          wbs_dat_i;
    logic [31:0]          wbs_dat64_i;
    logic                 wbs_ack_i;
    logic                 wbs_err_i;
    logic                 wbs_rty_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i, m_dat64_i,
        output m_dat_o, m_dat64_o, m_ack_o, m_err_o, m_rty_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cab_o, wbs_sel_o, wbs_adr_o,
        output wbs_dat_o, wbs_dat64_o,
        input  wbs_dat_i, wbs_dat64_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i, m_dat64_i,
        input  m_dat_o, m_dat64_o, m_ack_o, m_err_o, m_rty_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cab_o, wbs_sel_o, wbs_adr_o,
        input  wbs_dat_o, wbs_dat64_o,
        output wbs_dat_i, wbs_dat64_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface

// File: rtl/wb_master_arb.sv
// Round-robin arbiter sharing one 64-bit Wishbone master port between NREQ requesters,
// granting whole cyc-framed cycles, with a no-response watchdog that aborts hung transfers.
module wb_master_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_master_arb_if.master      bus,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 busy_o,
    output logic                 to_flag_o,
    output logic [2:0]           to_id_o,
    input  logic                 to_clear_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_GNT, S_ABORT, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic              to_flag_q, to_flag_d;
    logic [2:0]        to_id_q, to_id_d;

    logic [3:0]        sel_a   [NREQ];
    logic [31:0]       adr_a   [NREQ];
    logic [31:0]       dat_a   [NREQ];
    logic [31:0]       dat64_a [NREQ];

    logic              own_cyc, own_stb, rsp_any;
    logic [IW-1:0]     cand, pick;
    logic              pick_found;

    logic              cyc_c, stb_c, we_c, cab_c;
    logic [3:0]        sel_c;
    logic [31:0]       adr_c, dat_c, dat64_c;
    logic [NREQ-1:0]   ack_c, err_c, rty_c;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign sel_a[k]   = bus.m_sel_i[4*k +: 4];
        assign adr_a[k]   = bus.m_adr_i[32*k +: 32];
        assign dat_a[k]   = bus.m_dat_i[32*k +: 32];
        assign dat64_a[k] = bus.m_dat64_i[32*k +: 32];
    end

    assign own_cyc = bus.m_cyc_i[owner_q];
    assign own_stb = bus.m_stb_i[owner_q];
    assign rsp_any = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= IW'(NREQ - 1);
            gnt_q     <= '0;
            wdog_q    <= '0;
            to_flag_q <= 1'b0;
            to_id_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            wdog_q    <= wdog_d;
            to_flag_q <= to_flag_d;
            to_id_q   <= to_id_d;
        end
    end

    // Next-state: rotation search starts just after the last owner, so it is considered last.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        wdog_d     = wdog_q;
        to_flag_d  = to_flag_q & ~to_clear_i;
        to_id_d    = to_id_q;
        cand       = '0;
        pick       = ptr_q;
        pick_found = 1'b0;

        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = IW'((int'(ptr_q) + i) % int'(NREQ));
            if (!pick_found && bus.m_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_GNT;
                    owner_d = pick;
                    ptr_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                end
            end
            S_GNT: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (own_stb && !rsp_any && wdog_q == WW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                state_d   = S_DRAIN;
                to_flag_d = 1'b1;
                to_id_d   = 3'(owner_q);
            end
            S_DRAIN: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_GNT || !own_stb || rsp_any) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // Outputs: shared port follows the owner only while granted; responses reach the owner only.
    always_comb begin
        cyc_c   = 1'b0;
        stb_c   = 1'b0;
        we_c    = 1'b0;
        cab_c   = 1'b0;
        sel_c   = '0;
        adr_c   = '0;
        dat_c   = '0;
        dat64_c = '0;
        ack_c   = '0;
        err_c   = '0;
        rty_c   = '0;

        case (state_q)
            S_GNT: begin
                cyc_c          = own_cyc;
                stb_c          = own_stb;
                we_c           = bus.m_we_i[owner_q];
                cab_c          = bus.m_cab_i[owner_q];
                sel_c          = sel_a[owner_q];
                adr_c          = adr_a[owner_q];
                dat_c          = dat_a[owner_q];
                dat64_c        = dat64_a[owner_q];
                ack_c[owner_q] = bus.wbs_ack_i;
                err_c[owner_q] = bus.wbs_err_i;
                rty_c[owner_q] = bus.wbs_rty_i;
            end
            S_ABORT: err_c[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.wbs_cyc_o   = cyc_c;
    assign bus.wbs_stb_o   = stb_c;
    assign bus.wbs_we_o    = we_c;
    assign bus.wbs_cab_o   = cab_c;
    assign bus.wbs_sel_o   = sel_c;
    assign bus.wbs_adr_o   = adr_c;
    assign bus.wbs_dat_o   = dat_c;
    assign bus.wbs_dat64_o = dat64_c;
    assign bus.m_ack_o     = ack_c;
    assign bus.m_err_o     = err_c;
    assign bus.m_rty_o     = rty_c;
    assign bus.m_dat_o     = bus.wbs_dat_i;
    assign bus.m_dat64_o   = bus.wbs_dat64_i;

    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != S_IDLE);
    assign to_flag_o = to_flag_q;
    assign to_id_o   = to_id_q;

endmodule

// File: tb/tb_wb_master_arb.sv
// Scoreboard bench for wb_master_arb: directed requester sequences push expected grants and
// responses; a negedge monitor pops and compares whenever the DUT grants or responds.
module tb_wb_master_arb;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [3:0]  rty;
        logic [31:0] rdat;
        logic [31:0] rdat64;
        logic [31:0] wdat;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             to_flag;
    logic [2:0]       to_id;
    logic             to_clear;
    int               checks;
    int               errors;
    int               slv_mode;
    logic [3:0]       exp_gnt [$];
    rsp_t             exp_rsp [$];

    wb_master_arb_if #(.NREQ(NREQ)) bus ();

    wb_master_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .bus        (bus),
        .gnt_o      (gnt),
        .busy_o     (busy),
        .to_flag_o  (to_flag),
        .to_id_o    (to_id),
        .to_clear_i (to_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: 0 ack, 1 err, 2 rty on every strobe; 3 silent; 4 ack held high regardless.
    always_comb begin
        bus.wbs_ack_i   = 1'b0;
        bus.wbs_err_i   = 1'b0;
        bus.wbs_rty_i   = 1'b0;
        case (slv_mode)
            0: bus.wbs_ack_i = bus.wbs_cyc_o & bus.wbs_stb_o;
            1: bus.wbs_err_i = bus.wbs_cyc_o & bus.wbs_stb_o;
            2: bus.wbs_rty_i = bus.wbs_cyc_o & bus.wbs_stb_o;
            4: bus.wbs_ack_i = 1'b1;
            default: ;
        endcase
        bus.wbs_dat_i   = bus.wbs_adr_o ^ 32'hA5A5_0000;
        bus.wbs_dat64_i = ~bus.wbs_adr_o;
    end

    function automatic logic [31:0] adr_of(input int k);
        return 32'h1000_0000 | (32'(k) << 8);
    endfunction

    function automatic rsp_t mk(input int k, input int kind);
        rsp_t       r;
        logic [3:0] b;
        b = 4'b0001 << k;
        r = '0;
        case (kind)
            0:       r.ack = b;
            1:       r.err = b;
            default: r.rty = b;
        endcase
        r.rdat   = adr_of(k) ^ 32'hA5A5_0000;
        r.rdat64 = ~adr_of(k);
        r.wdat   = 32'hD000_0000 + 32'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int k, input logic cab);
        bus.m_cyc_i[2'(k)]               = 1'b1;
        bus.m_stb_i[2'(k)]               = 1'b1;
        bus.m_we_i[2'(k)]                = 1'b1;
        bus.m_cab_i[2'(k)]               = cab;
        bus.m_sel_i[4'(4*k) +: 4]        = 4'hF;
        bus.m_adr_i[7'(32*k) +: 32]      = adr_of(k);
        bus.m_dat_i[7'(32*k) +: 32]      = 32'hD000_0000 + 32'(k);
        bus.m_dat64_i[7'(32*k) +: 32]    = 32'hE000_0000 + 32'(k);
    endtask

    task automatic drop(input int k);
        bus.m_cyc_i[2'(k)] = 1'b0;
        bus.m_stb_i[2'(k)] = 1'b0;
        bus.m_cab_i[2'(k)] = 1'b0;
    endtask

    // Holds cyc/stb until 'beats' responses arrive (or the cycle budget runs out), then releases.
    task automatic req(input int k, input int beats, input logic cab);
        int cnt;
        int n;
        cnt = 0;
        n   = 0;
        raise(k, cab);
        while (cnt < beats && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.m_ack_o[2'(k)] | bus.m_err_o[2'(k)] | bus.m_rty_o[2'(k)]) cnt++;
        end
        checks++;
        if (cnt < beats) begin
            errors++;
            $display("FAIL req%0d_done: got %0d responses, required %0d", k, cnt, beats);
        end
        step();
        drop(k);
    endtask

    // Monitor: compares every new grant and every forwarded response against the queues.
    initial begin
        logic [3:0]   prev;
        logic [3:0]   eg;
        rsp_t         e;
        logic [107:0] act;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = gnt;
            end else begin
                if (gnt !== prev) begin
                    if (gnt != '0) begin
                        checks++;
                        if (exp_gnt.size() == 0) begin
                            errors++;
                            $display("FAIL grant: got %b, none required", gnt);
                        end else begin
                            eg = exp_gnt.pop_front();
                            if (gnt !== eg) begin
                                errors++;
                                $display("FAIL grant: got %b, required %b", gnt, eg);
                            end
                        end
                    end
                    prev = gnt;
                end
                if ((bus.m_ack_o | bus.m_err_o | bus.m_rty_o) != '0) begin
                    act = {bus.m_ack_o, bus.m_err_o, bus.m_rty_o,
                           bus.m_dat_o, bus.m_dat64_o, bus.wbs_dat_o};
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL response: got %h, none required", act);
                    end else begin
                        e = exp_rsp.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL response: got %h, required %h", act, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int got;
        checks        = 0;
        errors        = 0;
        slv_mode      = 0;
        rst           = 1'b1;
        to_clear      = 1'b0;
        bus.m_cyc_i   = '0;
        bus.m_stb_i   = '0;
        bus.m_we_i    = '0;
        bus.m_cab_i   = '0;
        bus.m_sel_i   = '0;
        bus.m_adr_i   = '0;
        bus.m_dat_i   = '0;
        bus.m_dat64_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_to_flag", 32'(to_flag), 32'd0);
        check("rst_to_id", 32'(to_id), 32'd0);
        check("rst_wbs_cyc", 32'(bus.wbs_cyc_o), 32'd0);
        check("rst_rsp", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 32'd0);
        step();
        rst = 1'b0;
        repeat (2) step();

        // Requests 0 and 2 together: 0 first with one-cycle latency, then 2 after an idle cycle.
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0100);
        exp_rsp.push_back(mk(0, 0));
        exp_rsp.push_back(mk(2, 0));
        fork
            req(0, 1, 1'b0);
            req(2, 1, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("gnt_latency", 32'(gnt), 32'd1);
            end
        join
        repeat (2) step();

        // Requester 1 cab burst of 4 while 0 and 3 wait: then 3, then 0.
        exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b1000);
        exp_gnt.push_back(4'b0001);
        repeat (4) exp_rsp.push_back(mk(1, 0));
        exp_rsp.push_back(mk(3, 0));
        exp_rsp.push_back(mk(0, 0));
        fork
            req(1, 4, 1'b1);
            begin
                step();
                step();
                fork
                    req(0, 1, 1'b0);
                    req(3, 1, 1'b0);
                join
            end
        join
        repeat (2) step();

        // Slave err then rty: routed only to the owner.
        slv_mode = 1;
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0001);
        exp_rsp.push_back(mk(2, 1));
        exp_rsp.push_back(mk(0, 1));
        fork
            req(2, 1, 1'b0);
            req(0, 1, 1'b0);
        join
        repeat (2) step();
        slv_mode = 2;
        exp_gnt.push_back(4'b0100);
        exp_rsp.push_back(mk(2, 2));
        req(2, 1, 1'b0);
        slv_mode = 0;
        repeat (2) step();

        // Watchdog abort on a silent slave, drain with a late ack, sticky flag and clear.
        slv_mode = 3;
        exp_gnt.push_back(4'b1000);
        exp_rsp.push_back({4'b0000, 4'b1000, 4'b0000, 32'hA5A5_0000, 32'hFFFF_FFFF, 32'h0});
        raise(3, 1'b0);
        n   = 0;
        got = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            @(negedge clk);
            if (bus.m_err_o[3]) got = 1;
            else if (bus.wbs_cyc_o) n++;
        end
        check("wdog_abort_seen", 32'(got), 32'd1);
        check("wdog_cyc_len", 32'(n), 32'd8);
        check("abort_cyc_low", 32'(bus.wbs_cyc_o), 32'd0);
        step();
        slv_mode = 4;
        @(negedge clk);
        check("to_flag_set", 32'(to_flag), 32'd1);
        check("to_id_set", 32'(to_id), 32'd3);
        check("err_one_pulse", 32'(bus.m_err_o), 32'd0);
        check("drain_cyc_low", 32'(bus.wbs_cyc_o), 32'd0);
        repeat (3) step();
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        check("late_ack_dropped", 32'(bus.m_ack_o), 32'd0);
        step();
        drop(3);
        slv_mode = 0;
        step();
        @(negedge clk);
        check("drain_exit_idle", 32'(busy), 32'd0);
        check("to_flag_sticky", 32'(to_flag), 32'd1);
        step();
        to_clear = 1'b1;
        step();
        to_clear = 1'b0;
        @(negedge clk);
        check("to_flag_cleared", 32'(to_flag), 32'd0);
        check("to_id_kept", 32'(to_id), 32'd3);
        repeat (2) step();

        // Reset mid-burst: everything drops, and requester 0 wins the next contention.
        slv_mode = 3;
        exp_gnt.push_back(4'b0010);
        raise(1, 1'b1);
        repeat (3) @(negedge clk);
        step();
        rst = 1'b1;
        step();
        drop(1);
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wbs", 32'({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_cab_o}), 32'd0);
        check("midrst_rsp", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 32'd0);
        step();
        rst      = 1'b0;
        slv_mode = 0;
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b0100);
        exp_rsp.push_back(mk(0, 0));
        exp_rsp.push_back(mk(1, 0));
        exp_rsp.push_back(mk(2, 0));
        step();
        fork
            req(0, 1, 1'b0);
            req(1, 1, 1'b0);
            req(2, 1, 1'b0);
        join
        repeat (3) step();

        check("exp_gnt_drained", 32'(exp_gnt.size()), 32'd0);
        check("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
